// File: rtl/rotary_led_sequencer.sv
// Rotary LED sequencer: edge-detects rotation events from the shaft detector,
// queues each step's direction in a small FIFO and replays the queued steps on
// an 8-LED bank at a human-visible rate, either as a walking dot or as a bar.
module rotary_led_sequencer #(
  parameter int unsigned STEP_CYCLES = 5000000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rotation_event,
  input  logic rotation_direction,
  input  logic mode,
  input  logic clr_ovf,
  output logic led0,
  output logic led1,
  output logic led2,
  output logic led3,
  output logic led4,
  output logic led5,
  output logic led6,
  output logic led7,
  output logic busy,
  output logic overflow
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned FillW  = PtrW + 1;
  // Timer only has to hold STEP_CYCLES-1; keep at least one bit for STEP_CYCLES=1.
  localparam int unsigned TimerW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  localparam logic [TimerW-1:0] TimerLoad = TimerW'(STEP_CYCLES - 1);
  localparam logic [FillW-1:0]  FillFull  = FillW'(FIFO_DEPTH);
  localparam logic [3:0]        BarMax    = 4'd8;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StHold = 1'b1;

  // Engine state
  logic [0:0]        state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              mode_r_q, mode_r_d;
  logic [7:0]        led_q, led_d;
  logic [3:0]        bar_cnt_q, bar_cnt_d;

  // Input edge detect and overflow flag
  logic prev_event_q;
  logic overflow_q;

  // Direction FIFO
  logic             fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [FillW-1:0] fill_q;

  logic push, pop, accept, drop;
  logic fifo_empty, fifo_full;
  logic mode_change;
  logic head_dir;

  // Thermometer code: LED i lit when i < cnt.
  function automatic logic [7:0] thermo(input logic [3:0] cnt);
    logic [7:0] t;
    for (int i = 0; i < 8; i++) begin
      t[i] = (4'(i) < cnt);
    end
    return t;
  endfunction

  // Push/pop decisions; a pop in the same cycle frees room for a push into a full FIFO.
  always_comb begin
    push        = rotation_event & ~prev_event_q;
    fifo_empty  = (fill_q == '0);
    fifo_full   = (fill_q == FillFull);
    mode_change = (state_q == StIdle) & (mode != mode_r_q);
    pop         = (state_q == StIdle) & ~mode_change & ~fifo_empty;
    accept      = push & (~fifo_full | pop);
    drop        = push & fifo_full & ~pop;
    head_dir    = fifo_q[rd_ptr_q];
  end

  // Step engine next state: mode re-init, step application and hold timing.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    mode_r_d  = mode_r_q;
    led_d     = led_q;
    bar_cnt_d = bar_cnt_q;
    case (state_q)
      StIdle: begin
        if (mode_change) begin
          // Mode change wins over a pending pop; the timer is left alone.
          mode_r_d = mode;
          if (mode) begin
            bar_cnt_d = 4'd0;
            led_d     = 8'b0000_0000;
          end else begin
            led_d = 8'b0000_0001;
          end
        end else if (pop) begin
          state_d = StHold;
          timer_d = TimerLoad;
          if (mode_r_q) begin
            if (head_dir) begin
              bar_cnt_d = (bar_cnt_q >= BarMax) ? BarMax : bar_cnt_q + 4'd1;
            end else begin
              bar_cnt_d = (bar_cnt_q == 4'd0) ? 4'd0 : bar_cnt_q - 4'd1;
            end
            led_d = thermo(bar_cnt_d);
          end else if (head_dir) begin
            led_d = {led_q[6:0], led_q[7]};
          end else begin
            led_d = {led_q[0], led_q[7:1]};
          end
        end
      end
      StHold: begin
        if (timer_q == '0) begin
          state_d = StIdle;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Engine, edge-detect and overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      mode_r_q     <= 1'b0;
      led_q        <= 8'b0000_0001;
      bar_cnt_q    <= 4'd0;
      prev_event_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      mode_r_q     <= mode_r_d;
      led_q        <= led_d;
      bar_cnt_q    <= bar_cnt_d;
      prev_event_q <= rotation_event;
      // A drop at the same edge as a clear leaves the flag set.
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (clr_ovf) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // FIFO pointers and fill level; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (accept) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({accept, pop})
        2'b10:   fill_q <= fill_q + FillW'(1);
        2'b01:   fill_q <= fill_q - FillW'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_q[wr_ptr_q] <= rotation_direction;
    end
  end

  assign {led7, led6, led5, led4, led3, led2, led1, led0} = led_q;
  assign busy     = (state_q != StIdle) | ~fifo_empty;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_rotary_led_sequencer.sv
// Self-checking bench for rotary_led_sequencer: directed scenarios plus a
// randomized phase, all compared every cycle against a queue-based model.
module tb_rotary_led_sequencer;

  localparam int unsigned S = 4;
  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ev = 1'b0;
  logic dir = 1'b0;
  logic mode = 1'b0;
  logic clr = 1'b0;
  logic l0, l1, l2, l3, l4, l5, l6, l7;
  logic busy, ovf;
  logic [7:0] leds;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: step queue, hold countdown, dot position and bar length.
  bit m_idle;
  int m_timer;
  bit m_q[$];
  bit m_prev;
  bit m_mode_r;
  bit m_ovf;
  int m_pos;
  int m_cnt;

  rotary_led_sequencer #(
    .STEP_CYCLES(S),
    .FIFO_DEPTH (D)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rotation_event    (ev),
    .rotation_direction(dir),
    .mode              (mode),
    .clr_ovf           (clr),
    .led0              (l0),
    .led1              (l1),
    .led2              (l2),
    .led3              (l3),
    .led4              (l4),
    .led5              (l5),
    .led6              (l6),
    .led7              (l7),
    .busy              (busy),
    .overflow          (ovf)
  );

  assign leds = {l7, l6, l5, l4, l3, l2, l1, l0};

  always #5 clk = ~clk;

  function automatic logic [7:0] m_led();
    if (m_mode_r) return 8'((1 << m_cnt) - 1);
    return 8'(1 << m_pos);
  endfunction

  function automatic logic m_busy();
    return (!m_idle) || (m_q.size() > 0);
  endfunction

  task automatic model_reset();
    m_idle   = 1'b1;
    m_timer  = 0;
    m_q.delete();
    m_prev   = 1'b0;
    m_mode_r = 1'b0;
    m_ovf    = 1'b0;
    m_pos    = 0;
    m_cnt    = 0;
  endtask

  task automatic model_edge();
    bit push, full, pop, d;
    push = ev && !m_prev;
    full = (m_q.size() == D);
    pop  = 1'b0;
    if (m_idle) begin
      if (mode != m_mode_r) begin
        m_mode_r = mode;
        if (mode) m_cnt = 0;
        else m_pos = 0;
      end else if (m_q.size() > 0) begin
        pop = 1'b1;
        d = m_q.pop_front();
        if (m_mode_r) m_cnt = d ? ((m_cnt < 8) ? m_cnt + 1 : 8) : ((m_cnt > 0) ? m_cnt - 1 : 0);
        else m_pos = d ? (m_pos + 1) % 8 : (m_pos + 7) % 8;
        m_idle  = 1'b0;
        m_timer = S - 1;
      end
    end else if (m_timer == 0) begin
      m_idle = 1'b1;
    end else begin
      m_timer--;
    end
    if (push && (!full || pop)) m_q.push_back(dir);
    if (push && full && !pop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_prev = ev;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_leds"}, 32'(leds), 32'(m_led()));
    check({tag, "_busy"}, 32'(busy), 32'(m_busy()));
    check({tag, "_ovf"},  32'(ovf),  32'(m_ovf));
  endtask

  // One clock: advance the model with the current inputs, then sample 1 ns after the edge.
  task automatic tick();
    if (!rst_n) model_reset();
    else model_edge();
    @(posedge clk);
    #1;
    check_model("cycle");
  endtask

  task automatic pulse(input logic d, input int high, input int low);
    ev  = 1'b1;
    dir = d;
    repeat (high) tick();
    ev = 1'b0;
    repeat (low) tick();
  endtask

  initial begin
    int nb;
    model_reset();

    // Reset, then quiet idle
    repeat (3) tick();
    rst_n = 1'b1;
    check("reset_leds", 32'(leds), 32'h01);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_ovf",  32'(ovf),  32'h0);
    repeat (50) tick();
    check("idle_leds", 32'(leds), 32'h01);

    // Single CW step from a 3-cycle-long pulse
    nb  = 0;
    ev  = 1'b1;
    dir = 1'b1;
    tick(); nb += int'(busy);
    tick(); nb += int'(busy);
    check("cw_step_leds", 32'(leds), 32'h02);
    tick(); nb += int'(busy);
    ev = 1'b0;
    repeat (17) begin tick(); nb += int'(busy); end
    check("cw_busy_len", 32'(nb), 32'd5);
    check("cw_single_leds", 32'(leds), 32'h02);

    // Back to led0, then a burst of four CCW pulses wrapping through led7
    pulse(1'b0, 1, 10);
    check("ccw_home_leds", 32'(leds), 32'h01);
    repeat (4) pulse(1'b0, 1, 1);
    repeat (25) tick();
    check("wrap_leds", 32'(leds), 32'h10);
    check("wrap_ovf", 32'(ovf), 32'h0);

    // Fast burst of eight CW pulses overflows the 4-deep FIFO
    repeat (8) pulse(1'b1, 1, 1);
    check("burst_ovf", 32'(ovf), 32'h1);
    repeat (40) tick();
    check("burst_leds", 32'(leds), 32'h08);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    check("clr_ovf", 32'(ovf), 32'h0);

    // Bar mode saturation in both directions
    mode = 1'b1;
    repeat (2) tick();
    check("bar_init_leds", 32'(leds), 32'h00);
    repeat (10) pulse(1'b1, 1, 6);
    check("bar_full_leds", 32'(leds), 32'hFF);
    repeat (10) pulse(1'b0, 1, 6);
    check("bar_empty_leds", 32'(leds), 32'h00);

    // Randomized traffic, including mode flips and overflow clears
    for (int i = 0; i < 1500; i++) begin
      ev  = ($urandom_range(0, 2) == 0);
      dir = 1'($urandom);
      clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 63) == 0) mode = ~mode;
      tick();
    end
    ev  = 1'b0;
    clr = 1'b1;
    repeat (120) tick();
    clr = 1'b0;

    // Reset while holding a step with three more queued
    mode = 1'b0;
    repeat (2) tick();
    repeat (5) pulse(1'b1, 1, 1);
    check("pre_reset_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("async_rst_leds", 32'(leds), 32'h01);
    check("async_rst_busy", 32'(busy), 32'h0);
    check("async_rst_ovf",  32'(ovf),  32'h0);
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (40) tick();
    check("post_rst_leds", 32'(leds), 32'h01);
    check("post_rst_busy", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
